// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding and line idle level.
// UART_TX_PARITY_EN (optional macro) enables the parity state in uart_tx_serializer.
package uart_pkg;

    // 3-bit state encoding shared by the UART blocks
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ARMED  = 3'd1;
    localparam logic [2:0] ST_START  = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_PARITY = 3'd4;
    localparam logic [2:0] ST_STOP   = 3'd5;

    // Marking level of the line; the receiver uses the same constant
    localparam logic UART_IDLE_LVL = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_ARMED  = ST_ARMED,
        S_START  = ST_START,
        S_DATA   = ST_DATA,
        S_PARITY = ST_PARITY,
        S_STOP   = ST_STOP
    } tx_state_e;

endpackage

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: turns accepted bytes into start/data/[parity]/stop
// frames, one bit per baud_tick. The tick generator lives beside this block.
// Optional macro UART_TX_PARITY_EN inserts an even-parity bit after the data.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 s_reset_n,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int CNT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

    tx_state_e              state_q, state_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]       cnt_q,   cnt_d;
    logic                   tx_q,    tx_d;
    logic                   ready_q, ready_d;
    logic                   busy_q,  busy_d;
    logic                   done_q,  done_d;
`ifdef UART_TX_PARITY_EN
    logic                   par_q,   par_d;
`endif

    // State and output registers; every output comes straight from a flop
    always_ff @(posedge clk) begin
        if (!s_reset_n) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            tx_q    <= UART_IDLE_LVL;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next-state and next-output logic; only baud_tick advances the frame
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                // ticks are ignored here, so a tick in the acceptance
                // cycle never starts the frame early
                tx_d = UART_IDLE_LVL;
                if (tx_valid && ready_q) begin
                    shreg_d = tx_data;
`ifdef UART_TX_PARITY_EN
                    // parity captured now because the shifter is consumed
                    par_d   = ^tx_data;
`endif
                    cnt_d   = '0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                // align the start bit to the tick grid
                if (baud_tick) begin
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_tick) begin
                    tx_d    = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    cnt_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                // cnt_q is the index of the bit currently on the line
                if (baud_tick) begin
                    if (cnt_q == LAST_BIT) begin
                        cnt_d   = '0;
`ifdef UART_TX_PARITY_EN
                        tx_d    = par_q;
                        state_d = S_PARITY;
`else
                        tx_d    = UART_IDLE_LVL;
                        state_d = S_STOP;
`endif
                    end else begin
                        tx_d    = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_tick) begin
                    tx_d    = UART_IDLE_LVL;
                    cnt_d   = '0;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // the final stop tick frees the block in the same cycle as
                // tx_done, so a waiting byte goes out on the very next tick
                if (baud_tick) begin
                    if (cnt_q == LAST_STOP) begin
                        cnt_d   = '0;
                        done_d  = 1'b1;
                        ready_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                tx_d    = UART_IDLE_LVL;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign tx       = tx_q;
    assign tx_ready = ready_q;
    assign tx_busy  = busy_q;
    assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: 8N1 instance plus an 8N2 instance.
// Frame expectations follow UART_TX_PARITY_EN when the bench is built with it.
module tb_uart_tx_serializer;

    logic       clk = 1'b0;
    logic       s_reset_n, baud_tick;
    logic       tx_valid, tx_valid2;
    logic [7:0] tx_data, tx_data2;
    logic       tx, tx_ready, tx_busy, tx_done;
    logic       tx2, tx_ready2, tx_busy2, tx_done2;

    int n_checks = 0;
    int n_pass   = 0;
    int period   = 4;
    int tcnt     = 0;
    bit sel      = 1'b0;

    always #5 clk = ~clk;

    uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(1)) u_dut (
        .clk(clk), .s_reset_n(s_reset_n), .baud_tick(baud_tick),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
    );

    uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(2)) u_dut2 (
        .clk(clk), .s_reset_n(s_reset_n), .baud_tick(baud_tick),
        .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
        .tx(tx2), .tx_busy(tx_busy2), .tx_done(tx_done2)
    );

    function automatic logic o_tx();    return sel ? tx2       : tx;       endfunction
    function automatic logic o_ready(); return sel ? tx_ready2 : tx_ready; endfunction
    function automatic logic o_busy();  return sel ? tx_busy2  : tx_busy;  endfunction
    function automatic logic o_done();  return sel ? tx_done2  : tx_done;  endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %b expected %b", tag, obs, exp);
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // One clock: wake on the falling edge, drive the tick for the next rise
    task automatic step();
        @(negedge clk);
        if (tcnt == period - 1) begin
            baud_tick = 1'b1;
            tcnt = 0;
        end else begin
            baud_tick = 1'b0;
            tcnt++;
        end
    endtask

    // Expected line bits in send order (bit 0 = start bit)
    task automatic mk_frame(input logic [7:0] d, input int stops,
                            output logic [31:0] f, output int n);
        f = '0;
        n = 1;
        for (int i = 0; i < 8; i++) begin f[n] = d[i]; n++; end
`ifdef UART_TX_PARITY_EN
        f[n] = ^d; n++;
`endif
        for (int s = 0; s < stops; s++) begin f[n] = 1'b1; n++; end
    endtask

    task automatic send(input string tag, input logic [7:0] d);
        int b = 0;
        while (o_ready() !== 1'b1 && b < 2000) begin step(); b++; end
        chk1({tag, " ready before send"}, o_ready(), 1'b1);
        if (sel) begin tx_valid2 = 1'b1; tx_data2 = d; end
        else     begin tx_valid  = 1'b1; tx_data  = d; end
        step();
        tx_valid  = 1'b0;
        tx_valid2 = 1'b0;
        chk1({tag, " busy after accept"}, o_busy(), 1'b1);
        chk1({tag, " ready after accept"}, o_ready(), 1'b0);
    endtask

    // Waits (bounded) for the start bit, checks every bit for a full period,
    // and returns on the sample where tx_done must be high.
    task automatic check_frame(input string tag, input logic [31:0] f, input int n);
        int   b  = 0;
        logic hs = 1'b1;
        logic ok;
        while (o_tx() !== 1'b0 && b < 2 * period + 4) begin step(); b++; end
        chk1({tag, " start seen"}, o_tx(), 1'b0);
        for (int i = 0; i < n; i++) begin
            ok = 1'b1;
            for (int k = 0; k < period; k++) begin
                if (o_tx() !== f[i]) ok = 1'b0;
                if (o_ready() !== 1'b0 || o_busy() !== 1'b1 || o_done() !== 1'b0) hs = 1'b0;
                step();
            end
            chk1($sformatf("%s bit%0d", tag, i), ok, 1'b1);
        end
        chk1({tag, " handshake during frame"}, hs, 1'b1);
        chk1({tag, " done at end"}, o_done(), 1'b1);
        chk1({tag, " ready at end"}, o_ready(), 1'b1);
        chk1({tag, " busy at end"}, o_busy(), 1'b0);
        chk1({tag, " line idle at end"}, o_tx(), 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] f;
        int          n, b, gap;
        logic        ok, seen;

        s_reset_n = 1'b0;
        baud_tick = 1'b0;
        tx_valid  = 1'b1;
        tx_data   = 8'hFF;
        tx_valid2 = 1'b0;
        tx_data2  = 8'h00;

        // T1: reset with tx_valid high
        repeat (3) step();
        chk1("T1 tx", tx, 1'b1);
        chk1("T1 ready", tx_ready, 1'b1);
        chk1("T1 busy", tx_busy, 1'b0);
        chk1("T1 done", tx_done, 1'b0);
        chk1("T1 tx2", tx2, 1'b1);
        tx_valid  = 1'b0;
        s_reset_n = 1'b1;
        step();
        chk1("T1 no accept", tx_busy, 1'b0);

        // T2: single 8'h55, 8N1
        send("T2", 8'h55);
        mk_frame(8'h55, 1, f, n);
        check_frame("T2", f, n);
        step();
        chk1("T2 done single pulse", tx_done, 1'b0);

        // T3: back-to-back A3 then 0F with tx_valid held
        tx_valid = 1'b1;
        tx_data  = 8'hA3;
        step();
        tx_data  = 8'h0F;
        chk1("T3 first accept", tx_busy, 1'b1);
        mk_frame(8'hA3, 1, f, n);
        check_frame("T3a", f, n);
        step();
        tx_valid = 1'b0;
        chk1("T3 second accept", tx_busy, 1'b1);
        gap = 1;
        while (tx !== 1'b0 && gap < 3 * period) begin step(); gap++; end
        chki("T3 idle clocks to next start", gap, period);
        mk_frame(8'h0F, 1, f, n);
        check_frame("T3b", f, n);

        // T4: tick coincident with acceptance; data changes mid-frame
        b = 0;
        while (baud_tick !== 1'b1 && b < 2 * period) begin step(); b++; end
        chk1("T4 tick aligned", baud_tick, 1'b1);
        tx_valid = 1'b1;
        tx_data  = 8'hC6;
        step();
        tx_valid = 1'b0;
        tx_data  = 8'hFF;
        ok = 1'b1;
        for (int k = 0; k < period; k++) begin
            if (tx !== 1'b1) ok = 1'b0;
            step();
        end
        chk1("T4 coincident tick ignored", ok, 1'b1);
        chk1("T4 start on next tick", tx, 1'b0);
        mk_frame(8'hC6, 1, f, n);
        check_frame("T4", f, n);

        // T5: reset during data bit 3 of 8'h00
        send("T5", 8'h00);
        b = 0;
        while (tx !== 1'b0 && b < 2 * period + 4) begin step(); b++; end
        repeat (4 * period + 1) step();
        chk1("T5 line low in bit3", tx, 1'b0);
        chk1("T5 busy in bit3", tx_busy, 1'b1);
        s_reset_n = 1'b0;
        step();
        s_reset_n = 1'b1;
        chk1("T5 tx after reset", tx, 1'b1);
        chk1("T5 busy after reset", tx_busy, 1'b0);
        chk1("T5 ready after reset", tx_ready, 1'b1);
        seen = 1'b0;
        ok   = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if (tx_done !== 1'b0) seen = 1'b1;
            if (tx !== 1'b1) ok = 1'b0;
            step();
        end
        chk1("T5 no done after abort", seen, 1'b0);
        chk1("T5 line stays idle", ok, 1'b1);
        send("T5n", 8'h81);
        mk_frame(8'h81, 1, f, n);
        check_frame("T5 next", f, n);

        // T6: 8'h07 on the 8N1 and the 8N2 instance
        send("T6a", 8'h07);
        mk_frame(8'h07, 1, f, n);
        check_frame("T6a", f, n);
        sel = 1'b1;
        send("T6b", 8'h07);
        mk_frame(8'h07, 2, f, n);
        check_frame("T6b", f, n);
        step();
        chk1("T6b done single pulse", tx_done2, 1'b0);
        sel = 1'b0;

        // Full-rate tick period
        period = 434;
        tcnt   = 0;
        send("FR", 8'h3C);
        mk_frame(8'h3C, 1, f, n);
        check_frame("FR", f, n);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
